main_fsm_dec: RTL and testbench

Multi-cycle main control unit for the MIPS CPU; it is the sequential successor to the single-cycle opcode decoder. A registered state machine steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and mux selects per state. It sits between the instruction register's opcode field and the shared-memory multi-cycle datapath. It supports an optional memory-ready handshake and keeps a retired-instruction counter.

---
 rtl/main_fsm_dec.sv | 198 +++++++++++++++++++
 tb/tb_main_fsm_dec.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm_dec.sv
// Multi-cycle MIPS main control FSM: per-state datapath controls,
// optional memory-ready stalls and a retired-instruction counter.
module main_fsm_dec #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 2,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               branch,
  output logic               iord,
  output logic               alusrca,
  output logic               regdst,
  output logic               memtoreg,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2'b10);

  state_t           state;
  state_t           state_n;
  logic             rdy;
  logic             retire;
  logic             pw;
  logic             ir;
  logic             rw;
  logic             mw;
  logic             ill;
  logic             is_r;
  logic             is_lw;
  logic             is_sw;
  logic             is_beq;
  logic             is_addi;
  logic             is_j;

  assign rdy = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  assign is_r    = (op == OP_R);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = FETCH;
    pw       = 1'b0;
    ir       = 1'b0;
    rw       = 1'b0;
    mw       = 1'b0;
    ill      = 1'b0;
    retire   = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        pw      = rdy;
        ir      = rdy;
        state_n = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          is_r:          state_n = EXEC;
          is_lw, is_sw:  state_n = MEMADR;
          is_beq:        state_n = BEQ;
          is_addi:       state_n = ADDIEX;
          is_j:          state_n = JUMP;
          default: begin
            state_n = FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_n = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        iord    = 1'b1;
        mw      = 1'b1;
        retire  = rdy;
        state_n = rdy ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FN;
        state_n = ALUWB;
      end
      ALUWB: begin
        regdst = 1'b1;
        rw     = 1'b1;
        retire = 1'b1;
      end
      BEQ: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = ADDIWB;
      end
      ADDIWB: begin
        rw     = 1'b1;
        retire = 1'b1;
      end
      JUMP: begin
        pcsrc  = 2'b10;
        pw     = 1'b1;
        retire = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  // Enables are squashed while reset is held so an aborted
  // instruction cannot write anything.
  assign pcwrite  = pw  & ~rst;
  assign irwrite  = ir  & ~rst;
  assign regwrite = rw  & ~rst;
  assign memwrite = mw  & ~rst;
  assign illegal  = ill & ~rst;
  assign state_o  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (retire) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_main_fsm_dec.sv
// Directed bench for main_fsm_dec: sequences, stalls,
// illegal ops, reset abort, MEM_WAIT=0 and counter wrap.
module tb_main_fsm_dec;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BQ   = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_nw = 1'b1;
  logic rst_w = 1'b1;
  logic [5:0] op = R;
  logic [5:0] op_nw = R;
  logic [5:0] op_w = J;
  logic mr = 1'b1;
  logic mr_nw = 1'b1;
  logic mr_w = 1'b1;

  wire [15:0] v;
  wire [15:0] v_nw;
  wire [15:0] v_w;
  wire [3:0] s;
  wire [3:0] s_nw;
  wire [3:0] s_w;
  wire [15:0] c;
  wire [15:0] c_nw;
  wire [3:0] c_w;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic pat [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] nw_st [6] = '{4'd0, 4'd1, 4'd2,
                            4'd3, 4'd4, 4'd0};

  always #5 clk = ~clk;

  main_fsm_dec dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mr),
    .pcwrite(v[15]), .irwrite(v[14]),
    .regwrite(v[13]), .memwrite(v[12]),
    .branch(v[11]), .iord(v[10]), .alusrca(v[9]),
    .regdst(v[8]), .memtoreg(v[7]),
    .alusrcb(v[6:5]), .pcsrc(v[4:3]),
    .aluop(v[2:1]), .illegal(v[0]),
    .state_o(s), .instr_cnt(c)
  );

  main_fsm_dec #(.MEM_WAIT(0)) dut_nw (
    .clk(clk), .rst(rst_nw), .op(op_nw), .mem_ready(mr_nw),
    .pcwrite(v_nw[15]), .irwrite(v_nw[14]),
    .regwrite(v_nw[13]), .memwrite(v_nw[12]),
    .branch(v_nw[11]), .iord(v_nw[10]), .alusrca(v_nw[9]),
    .regdst(v_nw[8]), .memtoreg(v_nw[7]),
    .alusrcb(v_nw[6:5]), .pcsrc(v_nw[4:3]),
    .aluop(v_nw[2:1]), .illegal(v_nw[0]),
    .state_o(s_nw), .instr_cnt(c_nw)
  );

  main_fsm_dec #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst_w), .op(op_w), .mem_ready(mr_w),
    .pcwrite(v_w[15]), .irwrite(v_w[14]),
    .regwrite(v_w[13]), .memwrite(v_w[12]),
    .branch(v_w[11]), .iord(v_w[10]), .alusrca(v_w[9]),
    .regdst(v_w[8]), .memtoreg(v_w[7]),
    .alusrcb(v_w[6:5]), .pcsrc(v_w[4:3]),
    .aluop(v_w[2:1]), .illegal(v_w[0]),
    .state_o(s_w), .instr_cnt(c_w)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit order: pw ir rw mw br iord asa rd mtr asb pcs aop ill
  function automatic logic [15:0] expv(input logic [3:0] st,
                                       input logic r,
                                       input logic [5:0] o);
    logic pw, ir, rw, mw, br, io, asa, rd, mtr, ill;
    logic [1:0] asb, pcs, aop;
    {pw, ir, rw, mw, br, io, asa, rd, mtr, ill} = '0;
    asb = 2'b00;
    pcs = 2'b00;
    aop = 2'b00;
    case (st)
      4'd0: begin pw = r; ir = r; asb = 2'b01; end
      4'd1: begin
        asb = 2'b11;
        ill = !(o inside {R, LW, SW, BQ, ADDI, J});
      end
      4'd2: begin asa = 1'b1; asb = 2'b10; end
      4'd3: io = 1'b1;
      4'd4: begin mtr = 1'b1; rw = 1'b1; end
      4'd5: begin io = 1'b1; mw = 1'b1; end
      4'd6: begin asa = 1'b1; aop = 2'b10; end
      4'd7: begin rd = 1'b1; rw = 1'b1; end
      4'd8: begin
        asa = 1'b1; aop = 2'b01;
        pcs = 2'b01; br = 1'b1;
      end
      4'd9: begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pcs = 2'b10; pw = 1'b1; end
      default: ;
    endcase
    return {pw, ir, rw, mw, br, io, asa, rd, mtr,
            asb, pcs, aop, ill};
  endfunction

  // Entered at a negedge; leaves at the next negedge.
  task automatic cyc(input logic [3:0] st,
                     input logic [5:0] o,
                     input logic r);
    op = o;
    mr = r;
    #1;
    chk($sformatf("state@%0d", st), 32'(s), 32'(st));
    chk($sformatf("outs@%0d", st), 32'(v), 32'(expv(st, r, o)));
    chk($sformatf("cnt@%0d", st), 32'(c), 32'(exp_cnt));
    if (st inside {4'd4, 4'd7, 4'd8, 4'd10, 4'd11} ||
        (st == 4'd5 && r))
      exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(s), 32'd0);
    chk("rst_cnt", 32'(c), 32'd0);
    chk("rst_outs", 32'(v), 32'(expv(4'd0, 1'b0, R)));
    @(negedge clk);
    rst = 1'b0;

    cyc(0, R, 1); cyc(1, R, 1); cyc(6, R, 1); cyc(7, R, 1);
    cyc(0, LW, 1); cyc(1, LW, 1); cyc(2, LW, 1);
    cyc(3, LW, 1); cyc(4, LW, 1);
    cyc(0, SW, 1); cyc(1, SW, 1); cyc(2, SW, 1); cyc(5, SW, 1);
    cyc(0, BQ, 1); cyc(1, BQ, 1); cyc(8, BQ, 1);
    cyc(0, ADDI, 1); cyc(1, ADDI, 1);
    cyc(9, ADDI, 1); cyc(10, ADDI, 1);
    cyc(0, J, 1); cyc(1, J, 1); cyc(11, J, 1);
    #1;
    chk("seq_cnt6", 32'(c), 32'd6);

    for (int i = 0; i < 3; i++) cyc(0, LW, 0);
    cyc(0, LW, 1); cyc(1, LW, 1); cyc(2, LW, 1);
    cyc(3, LW, 0); cyc(3, LW, 0); cyc(3, LW, 1);
    cyc(4, LW, 1);
    #1;
    chk("stall_cnt7", 32'(c), 32'd7);

    cyc(0, SW, 1); cyc(1, SW, 1); cyc(2, SW, 1);
    cyc(5, SW, 0); cyc(5, SW, 0); cyc(5, SW, 1);
    #1;
    chk("sw_cnt8", 32'(c), 32'd8);

    cyc(0, BAD, 1); cyc(1, BAD, 1);
    cyc(0, R, 0);
    #1;
    chk("ill_cnt8", 32'(c), 32'd8);

    cyc(0, LW, 1); cyc(1, LW, 1); cyc(2, LW, 1);
    cyc(3, LW, 0);
    rst = 1'b1;
    mr = 1'b1;
    #1;
    chk("abort_state", 32'(s), 32'd0);
    chk("abort_cnt", 32'(c), 32'd0);
    chk("abort_en", 32'(v[15:12]), 32'd0);
    chk("abort_ill", 32'(v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    cyc(0, R, 1); cyc(1, R, 1);

    rst_nw = 1'b0;
    op_nw = LW;
    for (int i = 0; i < 6; i++) begin
      mr_nw = pat[i];
      #1;
      chk($sformatf("nw_state%0d", i), 32'(s_nw), 32'(nw_st[i]));
      if (i == 0) chk("nw_irwrite", 32'(v_nw[14]), 32'd1);
      if (i == 5) chk("nw_cnt", 32'(c_nw), 32'd1);
      @(negedge clk);
    end

    rst_w = 1'b0;
    repeat (48) @(negedge clk);
    #1;
    chk("wrap_cnt16", 32'(c_w), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap_cnt17", 32'(c_w), 32'd1);
    chk("wrap_state", 32'(s_w), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
